// File: rtl/mem_dbus_bridge.sv
// MEM-stage RAM port to handshaked data bus bridge: registers one access, runs req/gnt/rvalid, stalls the pipe.
// Latency: load 3 + gnt wait + rvalid wait cycles, store 2 + gnt wait; stall_req holds the pipeline until DONE.
module mem_dbus_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic        ram_write_en,
    input  logic [3:0]  ram_write_sel,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    input  logic        pipe_hold,
    input  logic        flush,
    output logic [31:0] ram_read_data,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             killed;
    logic             timeout;

    assign timeout       = (cnt == CNT_LAST);
    assign stall_req     = ((state == IDLE) && ram_en && !flush) || (state == REQ) || (state == WAIT);
    assign ram_read_data = (state == DONE) ? rdata_q : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            cnt       <= '0;
            bus_err   <= 1'b0;
            killed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    killed <= 1'b0;
                    if (ram_en && !flush) begin
                        bus_we    <= ram_write_en;
                        bus_sel   <= ram_write_en ? ram_write_sel : 4'hF;
                        bus_addr  <= {ram_addr[31:2], 2'b00};
                        bus_wdata <= ram_write_data;
                        cnt       <= '0;
                        // A store with no byte lanes has nothing to put on the bus.
                        if (ram_write_en && (ram_write_sel == 4'h0)) begin
                            state <= DONE;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= bus_we ? DONE : WAIT;
                    end else if (flush) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata_q <= 32'hFFFF_FFFF;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // A killed load must still drain its response before the bus is reused.
                    if (bus_rvalid) begin
                        if (killed || flush) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= bus_rdata;
                            state   <= DONE;
                        end
                    end else if (timeout) begin
                        bus_err <= 1'b1;
                        if (killed || flush) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= 32'hFFFF_FFFF;
                            state   <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (flush) begin
                            killed <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flush || !pipe_hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus_bridge.sv
// Scoreboard bench for mem_dbus_bridge: random MEM accesses against a word-array memory model and a behavioural bus slave.
module tb_mem_dbus_bridge;

    localparam int TMO = 8;

    typedef struct packed {
        logic        is_load;
        logic        err;
        logic [31:0] data;
    } cpl_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic        ram_write_en;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        pipe_hold;
    logic        flush;
    logic [31:0] ram_read_data;
    logic        stall_req;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    logic [31:0] sram    [16];
    logic [31:0] ref_mem [16];
    cpl_t        cq[$];
    req_t        rq[$];
    int          gnt_dly;
    int          rv_dly;
    logic        slave_on;
    logic        err_model;
    int          total;
    int          bad;

    mem_dbus_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_write_sel(ram_write_sel), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .pipe_hold(pipe_hold), .flush(flush), .ram_read_data(ram_read_data),
        .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_bus_sel"}, 32'(bus_sel), 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_stall_req"}, 32'(stall_req), 32'd0);
        chk({tag, "_ram_read_data"}, ram_read_data, 32'd0);
    endtask

    // Bus slave: grants after gnt_dly cycles, returns a word from sram after rv_dly cycles.
    initial begin
        int   gw;
        int   rw;
        int   pidx;
        int   widx;
        logic seen;
        logic pend;
        req_t e;
        gw = 0; rw = 0; pidx = 0; widx = 0; seen = 1'b0; pend = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            if (rst) begin
                seen = 1'b0;
                pend = 1'b0;
            end else if (pend) begin
                if (rw > 0) rw--;
                else begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = sram[pidx];
                    pend       = 1'b0;
                end
            end else if (bus_req && slave_on) begin
                if (!seen) begin
                    seen = 1'b1;
                    gw   = gnt_dly;
                end
                if (gw > 0) gw--;
                else begin
                    bus_gnt = 1'b1;
                    seen    = 1'b0;
                    if (rq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_bus_req: addr %h with no access pending", bus_addr);
                    end else begin
                        e = rq.pop_front();
                        chk("bus_we", 32'(bus_we), 32'(e.we));
                        chk("bus_sel", 32'(bus_sel), 32'(e.sel));
                        chk("bus_addr", bus_addr, e.addr);
                        if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                    end
                    widx = int'(bus_addr[5:2]);
                    if (bus_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_sel[b]) sram[widx][8*b +: 8] = bus_wdata[8*b +: 8];
                    end else begin
                        pend = 1'b1;
                        rw   = rv_dly;
                        pidx = widx;
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Completion monitor: the first stall-free cycle of a live access is its DONE cycle.
    initial begin
        logic prev_stall;
        cpl_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ram_en && !flush && !stall_req && prev_stall) begin
                if (cq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_completion: rdata %h", ram_read_data);
                end else begin
                    e = cq.pop_front();
                    if (e.is_load) chk("ram_read_data", ram_read_data, e.data);
                    chk("done_bus_err", 32'(bus_err), 32'(e.err));
                end
            end
            prev_stall = stall_req;
        end
    end

    task automatic access(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                          input int gd, input int rd, input int hold, input logic tmo);
        int          idx;
        int          n;
        int          exp_n;
        logic [31:0] exp_d;
        logic        done;
        idx   = int'(a[5:2]);
        exp_d = 32'h0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            if (s != 4'h0) rq.push_back('{1'b1, s, {a[31:2], 2'b00}, d});
            exp_n = (s == 4'h0) ? 1 : 2 + gd;
        end else if (tmo) begin
            exp_d     = 32'hFFFF_FFFF;
            err_model = 1'b1;
            exp_n     = 1 + TMO;
        end else begin
            exp_d = ref_mem[idx];
            rq.push_back('{1'b0, 4'hF, {a[31:2], 2'b00}, d});
            exp_n = 3 + gd + rd;
        end
        cq.push_back('{~w, err_model, exp_d});
        gnt_dly = gd;
        rv_dly  = rd;
        ram_en = 1'b1; ram_write_en = w; ram_write_sel = s; ram_addr = a; ram_write_data = d;
        n = 1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            if (!stall_req) done = 1'b1;
            else n++;
        end
        chk("access_completes", 32'(done), 32'd1);
        chk("stall_cycles", 32'(n), 32'(exp_n));
        pipe_hold = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_stall", 32'(stall_req), 32'd0);
            chk("hold_no_req", 32'(bus_req), 32'd0);
            if (!w) chk("hold_rdata", ram_read_data, exp_d);
            if (h == hold - 1) pipe_hold = 1'b0;
        end
        @(posedge clk); #1;
        ram_en = 1'b0;
    endtask

    initial begin
        int n;
        total = 0; bad = 0;
        rst = 1'b1; ram_en = 1'b0; ram_write_en = 1'b0; ram_write_sel = 4'h0;
        ram_addr = 32'h0; ram_write_data = 32'h0; pipe_hold = 1'b0; flush = 1'b0;
        gnt_dly = 0; rv_dly = 0; slave_on = 1'b1; err_model = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[0] = 32'hA1B2_C3D4; ref_mem[0] = 32'hA1B2_C3D4;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // zero-wait load, delayed-grant byte store, back-to-back loads, held DONE
        access(1'b0, 4'h0, 32'h0000_1003, 32'h0, 0, 0, 0, 1'b0);
        access(1'b1, 4'b0100, 32'h0000_1004, 32'h5A5A_5A5A, 4, 0, 0, 1'b0);
        access(1'b0, 4'h0, 32'h0000_2000, 32'h0, 0, 1, 0, 1'b0);
        access(1'b0, 4'h0, 32'h0000_2000, 32'h0, 1, 0, 0, 1'b0);
        access(1'b0, 4'h0, 32'h0000_1004, 32'h0, 0, 2, 3, 1'b0);
        access(1'b1, 4'h0, 32'h0000_1008, 32'h1234_5678, 0, 0, 0, 1'b0);

        // flush while waiting for grant: request withdrawn, nothing reaches the bus
        slave_on = 1'b0;
        ram_en = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h0000_100C;
        @(posedge clk); #1;
        chk("flush_req_stall", 32'(stall_req), 32'd1);
        chk("flush_req_bus_req", 32'(bus_req), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ram_en = 1'b0;
        chk("flush_req_dropped", 32'(bus_req), 32'd0);
        chk("flush_req_idle_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        chk("flush_req_no_reissue", 32'(bus_req), 32'd0);
        slave_on = 1'b1;

        // flush while waiting for read data: response still drained, then discarded
        gnt_dly = 0; rv_dly = 3;
        rq.push_back('{1'b0, 4'hF, 32'h0000_1008, 32'h0});
        ram_en = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h0000_1008;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (stall_req) n++;
            if (!bus_req) break;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        if (stall_req) n++;
        flush = 1'b0; ram_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!stall_req) break;
            n++;
        end
        chk("flush_wait_stall_cycles", 32'(n), 32'd6);
        chk("flush_wait_rdata_dropped", ram_read_data, 32'd0);

        for (int t = 0; t < 40; t++) begin
            logic        w;
            logic [3:0]  s;
            logic [31:0] a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            a = {26'h40, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            d = $urandom;
            access(w, s, a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        // grant never arrives: access aborted with the sticky error flag
        slave_on = 1'b0;
        access(1'b0, 4'h0, 32'h0000_1010, 32'h0, 0, 0, 1, 1'b1);
        chk("timeout_err_sticky", 32'(bus_err), 32'd1);
        slave_on = 1'b1;

        // reset while waiting for read data
        gnt_dly = 0; rv_dly = 5;
        rq.push_back('{1'b0, 4'hF, 32'h0000_1014, 32'h0});
        ram_en = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h0000_1014;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!bus_req) break;
        end
        rst = 1'b1; ram_en = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("rst_in_wait");
        @(posedge clk); #1;
        rst = 1'b0; err_model = 1'b0;
        access(1'b0, 4'h0, 32'h0000_1004, 32'h0, 1, 1, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("completions_drained", 32'(cq.size()), 32'd0);
        chk("bus_reqs_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
